// File: rtl/spi_tx_arbiter_pkg.sv
// Shared configuration for the SPI transmit path: default widths, requester count,
// watchdog limit and the arbiter state encoding.
package spi_tx_arbiter_pkg;

  localparam int CFG_DATA_WIDTH = 8;
  localparam int CFG_REQ_NUM    = 2;
  localparam int CFG_TIMEOUT    = 1023;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

  // A single requester still needs a 1-bit pointer.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest set request at or above start, else lowest
// set request overall (wrap). Reusable by any shared-resource arbiter.
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [N-1:0] hi;
  logic [N-1:0] sel;

  always_comb begin
    hi     = '0;
    onehot = '0;
    idx    = '0;
    any    = |req;
    for (int j = 0; j < N; j++)
      hi[j] = req[j] && (j >= int'(start));
    sel = (|hi) ? hi : req;
    // Descending scan so the lowest matching index is the one left standing.
    for (int j = N - 1; j >= 0; j--) begin
      if (sel[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = PW'(j);
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter sharing one SPI transmitter between word sources; the grant is
// held for a whole frame, with a one-entry output register and a requester-stall watchdog.
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int P_DATA_WIDTH = spi_tx_arbiter_pkg::CFG_DATA_WIDTH,
  parameter int P_REQ_NUM    = spi_tx_arbiter_pkg::CFG_REQ_NUM,
  parameter int P_TIMEOUT    = spi_tx_arbiter_pkg::CFG_TIMEOUT
) (
  input  logic                           clk_100,
  input  logic                           a_rst,
  input  logic [P_REQ_NUM-1:0]           req_valid,
  input  logic [P_REQ_NUM*P_DATA_WIDTH-1:0] req_data,
  input  logic [P_REQ_NUM-1:0]           req_last,
  output logic [P_REQ_NUM-1:0]           req_ready,
  output logic                           m_valid,
  output logic [P_DATA_WIDTH-1:0]        m_data,
  input  logic                           m_ready,
  output logic [P_REQ_NUM-1:0]           grant,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout_err,
  output logic [15:0]                    frame_cnt
);

  localparam int PW    = ptr_w(P_REQ_NUM);
  localparam int WDW   = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
  localparam bit WD_EN = (P_TIMEOUT > 0);

  arb_state_t             state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          gidx;
  logic [WDW-1:0]         wdog;
  logic [P_REQ_NUM-1:0]   pick_oh;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;
  logic [P_DATA_WIDTH-1:0] data_sel;
  logic                   last_sel;
  logic                   open;
  logic                   xfer;
  logic                   stall;
  logic                   wd_fire;
  logic [PW-1:0]          nxt_ptr;

  rr_pick #(.N(P_REQ_NUM), .PW(PW)) u_pick (
    .req    (req_valid),
    .start  (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Output register can take a word when empty or draining this cycle.
  assign open      = ~m_valid | m_ready;
  assign req_ready = (state == ARB_LOCK && open) ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    data_sel = '0;
    last_sel = 1'b0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      if (grant[i]) begin
        data_sel = req_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
        last_sel = req_last[i];
      end
    end
  end

  // Only a requester that could have sent but did not counts as stalled.
  assign stall   = (state == ARB_LOCK) && open && !xfer;
  assign wd_fire = WD_EN && stall && (wdog == WDW'(P_TIMEOUT - 1));
  assign nxt_ptr = (gidx == PW'(P_REQ_NUM - 1)) ? '0 : gidx + PW'(1);

  always_ff @(posedge clk_100 or negedge a_rst) begin
    if (!a_rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      gidx        <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      wdog        <= '0;
    end else begin
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;

      if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= data_sel;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          wdog <= '0;
          if (pick_any) begin
            state <= ARB_LOCK;
            grant <= pick_oh;
            gidx  <= pick_idx;
            busy  <= 1'b1;
          end
        end
        ARB_LOCK: begin
          if (xfer) begin
            wdog <= '0;
            if (last_sel) begin
              state      <= ARB_IDLE;
              grant      <= '0;
              busy       <= 1'b0;
              rr_ptr     <= nxt_ptr;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end
          end else if (wd_fire) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            rr_ptr      <= nxt_ptr;
            timeout_err <= 1'b1;
            wdog        <= '0;
          end else if (WD_EN && stall) begin
            wdog <= wdog + WDW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk_100) disable iff (!a_rst) $onehot0(grant));

endmodule
